// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter feeding one APB master port. Grant -> SETUP 1 cycle -> ACCESS >=1 cycle -> response 1 cycle later.
// Backpressure: requesters hold req_valid until req_ready; one transfer in flight; ACCESS aborts after TIMEOUT cycles without pready.
module apb_rr_master_arb #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   gnt_sel;
  logic [IW-1:0]   idx;
  logic            gnt_found;
  logic [CW-1:0]   wait_cnt;

  // Scan downwards so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k >= NREQ) ? IW'(int'(ptr) + k - NREQ) : IW'(int'(ptr) + k);
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_sel   = idx;
      end
    end
  end

  // Gated by presetn so nothing is accepted while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (presetn && state == IDLE && gnt_found) begin
      req_ready[gnt_sel] = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      wait_cnt  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt    <= gnt_sel;
            pwrite <= req_write[gnt_sel];
            paddr  <= req_addr[gnt_sel*AW +: AW];
            pwdata <= req_wdata[gnt_sel*DW +: DW];
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // pready wins over the timeout when both land on the same cycle.
          if (pready || wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid[gnt] <= 1'b1;
            rsp_err        <= pready ? pslverr : 1'b1;
            rsp_rdata      <= (pready && !pwrite) ? prdata : '0;
            ptr            <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            psel           <= 1'b0;
            penable        <= 1'b0;
            pwrite         <= 1'b0;
            paddr          <= '0;
            pwdata         <= '0;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Bench for apb_rr_master_arb: per-requester queues, reactive APB slave, cycle-age transaction model.
module tb_apb_rr_master_arb;

  localparam int NREQ    = 4;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic               pclk = 1'b0;
  logic               presetn;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*AW-1:0] req_addr  = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               psel, penable, pwrite;
  logic [AW-1:0]      paddr;
  logic [DW-1:0]      pwdata;
  logic [DW-1:0]      prdata  = '0;
  logic               pready  = 1'b0;
  logic               pslverr = 1'b0;

  apb_rr_master_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  txn_t rq[NREQ][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.w = w;
    t.a = a;
    t.d = d;
    rq[i].push_back(t);
  endtask

  // Requesters: present the head of each queue, pop it once it is accepted.
  initial forever begin
    @(negedge pclk);
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]            = 1'b1;
        req_write[i]            = rq[i][0].w;
        req_addr[i*AW +: AW]    = rq[i][0].a;
        req_wdata[i*DW +: DW]   = rq[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
    end
  end

  // Slave: pready after slv_wait ACCESS cycles; pslverr and prdata are noisy outside the sampling edge.
  int            slv_wait  = 0;
  logic          slv_err   = 1'b0;
  logic          slv_stray = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_cnt   = 0;

  initial forever begin
    @(negedge pclk);
    if (psel && penable) begin
      pready  = (acc_cnt >= slv_wait);
      pslverr = pready ? slv_err : 1'b1;
      acc_cnt++;
    end else begin
      pready  = slv_stray;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
    prdata = slv_rdata;
  end

  // Model: a transfer is tracked by its age in cycles since grant (1 = SETUP, >=2 = ACCESS).
  logic          m_busy = 1'b0, m_w = 1'b0, m_rsp = 1'b0, m_rerr = 1'b0;
  int            m_t = 0, m_g = 0, m_rg = 0, m_ptr = 0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0, m_rdata = '0;

  int cyc = 0, psel_cnt = 0, pen_cnt = 0;
  int grant_idx[$], grant_cyc[$], rsp_idx[$], rsp_cyc[$];
  logic rsp_err_q[$];
  logic [DW-1:0] rsp_data_q[$];

  always @(negedge pclk) begin
    int eg;
    logic [NREQ-1:0] erdy;
    #1;
    cyc++;
    if (!presetn) begin
      chk("rst_ctrl", {psel, penable, pwrite, rsp_err, rsp_valid, req_ready}, 0);
      chk("rst_data", {paddr, pwdata, rsp_rdata}, 0);
      m_busy = 1'b0;
      m_rsp  = 1'b0;
      m_ptr  = 0;
    end else begin
      eg   = -1;
      erdy = '0;
      if (!m_busy) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req_valid[(m_ptr + k) % NREQ]) eg = (m_ptr + k) % NREQ;
        end
        if (eg >= 0) erdy[eg] = 1'b1;
      end
      chk("req_ready", req_ready, erdy);
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_t >= 2);
      if (m_busy) begin
        chk("paddr", paddr, m_a);
        chk("pwrite", pwrite, m_w);
        chk("pwdata", pwdata, m_d);
      end
      chk("rsp_valid", rsp_valid, m_rsp ? (NREQ'(1) << m_rg) : NREQ'(0));
      if (m_rsp) begin
        chk("rsp_err", rsp_err, m_rerr);
        chk("rsp_rdata", rsp_rdata, m_rdata);
      end

      psel_cnt += int'(psel);
      pen_cnt  += int'(penable);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin grant_idx.push_back(i); grant_cyc.push_back(cyc); end
        if (rsp_valid[i]) begin
          rsp_idx.push_back(i); rsp_cyc.push_back(cyc);
          rsp_err_q.push_back(rsp_err); rsp_data_q.push_back(rsp_rdata);
        end
      end

      m_rsp = 1'b0;
      if (m_busy) begin
        if (m_t >= 2 && (pready || (m_t - 2) == TIMEOUT - 1)) begin
          m_rsp   = 1'b1;
          m_rg    = m_g;
          m_rerr  = pready ? pslverr : 1'b1;
          m_rdata = (pready && !m_w) ? prdata : '0;
          m_ptr   = (m_g + 1) % NREQ;
          m_busy  = 1'b0;
        end else begin
          m_t++;
        end
      end else if (eg >= 0) begin
        m_busy = 1'b1;
        m_t    = 1;
        m_g    = eg;
        m_w    = req_write[eg];
        m_a    = req_addr[eg*AW +: AW];
        m_d    = req_wdata[eg*DW +: DW];
      end
    end
  end

  task automatic wait_rsps(input int n);
    for (int k = 0; k < 200; k++) begin
      @(negedge pclk);
      #2;
      if (rsp_idx.size() >= n) break;
    end
    if (rsp_idx.size() < n) chk("rsp_wait_budget", rsp_idx.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r;
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    #3 presetn = 1'b1;

    // Round-robin: everyone requesting at once, ptr starts at 0.
    @(posedge pclk); #1;
    g = grant_idx.size(); r = rsp_idx.size();
    slv_wait = 0; slv_rdata = 32'hDEAD_BEEF;
    push(0, 1'b1, 8'h20, 32'h1111_0000);
    push(1, 1'b1, 8'h21, 32'h2222_0001);
    push(2, 1'b1, 8'h22, 32'h3333_0002);
    push(3, 1'b1, 8'h23, 32'h4444_0003);
    push(0, 1'b1, 8'h24, 32'h5555_0000);
    wait_rsps(r + 5);
    for (int k = 0; k < 5; k++) chk("rr_order", grant_idx[g+k], rr_exp[k]);
    for (int k = 1; k < 5; k++) chk("rr_spacing", grant_cyc[g+k] - grant_cyc[g+k-1], 3);

    // Single read with zero wait states.
    @(posedge pclk); #1;
    g = grant_idx.size(); r = rsp_idx.size();
    slv_rdata = 32'hA5A5_0001; psel_cnt = 0; pen_cnt = 0;
    push(0, 1'b0, 8'h10, 32'h0);
    wait_rsps(r + 1);
    chk("rd_idx", rsp_idx[r], 0);
    chk("rd_latency", rsp_cyc[r] - grant_cyc[g], 3);
    chk("rd_data", rsp_data_q[r], 32'hA5A5_0001);
    chk("rd_err", rsp_err_q[r], 0);
    chk("rd_psel_cycles", psel_cnt, 2);
    chk("rd_penable_cycles", pen_cnt, 1);

    // Five wait states then pslverr.
    @(posedge pclk); #1;
    g = grant_idx.size(); r = rsp_idx.size();
    slv_wait = 5; slv_err = 1'b1; pen_cnt = 0;
    push(2, 1'b1, 8'h30, 32'hCAFE_0002);
    wait_rsps(r + 1);
    chk("ws_idx", rsp_idx[r], 2);
    chk("ws_err", rsp_err_q[r], 1);
    chk("ws_wdata_rsp_zero", rsp_data_q[r], 0);
    chk("ws_penable_cycles", pen_cnt, 6);
    chk("ws_latency", rsp_cyc[r] - grant_cyc[g], 8);

    // Timeout on req 3 with req 0 queued behind it; stray pready outside ACCESS.
    @(posedge pclk); #1;
    g = grant_idx.size(); r = rsp_idx.size();
    slv_wait = 1000; slv_err = 1'b0; slv_stray = 1'b1; pen_cnt = 0;
    push(3, 1'b0, 8'h3C, 32'h0);
    push(0, 1'b0, 8'h0C, 32'h0);
    wait_rsps(r + 1);
    slv_wait = 0; slv_stray = 1'b0;
    chk("to_idx", rsp_idx[r], 3);
    chk("to_err", rsp_err_q[r], 1);
    chk("to_rdata", rsp_data_q[r], 0);
    chk("to_penable_cycles", pen_cnt, 16);
    chk("to_latency", rsp_cyc[r] - grant_cyc[g], 18);
    wait_rsps(r + 2);
    chk("to_next_idx", grant_idx[g+1], 0);
    chk("to_next_cycle", grant_cyc[g+1], rsp_cyc[r]);
    chk("to_next_err", rsp_err_q[r+1], 0);

    // Back-to-back: req 1 re-requests in its own response cycle.
    g = grant_idx.size(); r = rsp_idx.size();
    slv_rdata = 32'h0BB0_0001;
    push(1, 1'b0, 8'h44, 32'h0);
    for (int k = 0; k < 50; k++) begin
      @(posedge pclk); #1;
      if (rsp_valid[1]) break;
    end
    push(1, 1'b1, 8'h48, 32'h7777_0001);
    wait_rsps(r + 2);
    chk("b2b_idx", grant_idx[g+1], 1);
    chk("b2b_grant_cycle", grant_cyc[g+1], rsp_cyc[r]);
    chk("b2b_rsp_spacing", rsp_cyc[r+1] - rsp_cyc[r], 3);

    // Reset during ACCESS of req 3 (ptr=3); pending 2 and 3 must restart from ptr=0.
    r = rsp_idx.size();
    push(2, 1'b1, 8'h50, 32'h0000_5050);
    wait_rsps(r + 1);
    g = grant_idx.size();
    slv_wait = 1000;
    push(3, 1'b0, 8'h58, 32'h0);
    repeat (5) @(negedge pclk);
    #2;
    push(2, 1'b1, 8'h60, 32'h0000_6060);
    push(3, 1'b1, 8'h64, 32'h0000_6464);
    r = rsp_idx.size();
    g = grant_idx.size();
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    slv_wait = 0;
    repeat (2) @(negedge pclk);
    @(posedge pclk); #3;
    presetn = 1'b1;
    wait_rsps(r + 2);
    chk("arst_first_grant", grant_idx[g], 2);
    chk("arst_second_grant", grant_idx[g+1], 3);
    chk("arst_first_rsp", rsp_idx[r], 2);
    chk("arst_second_rsp", rsp_idx[r+1], 3);

    repeat (3) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
